// File: rtl/cnn2d_frame_sequencer_if.sv
// Bus bundle for the CNN frame sequencer: pixel input stream, engine-side pixel/score
// signals and the downstream result handshake.
interface cnn2d_frame_sequencer_if #(
    parameter int bitWidth   = 16,
    parameter int outputSize = 10
);
    localparam int CLS_W = (outputSize > 1) ? $clog2(outputSize) : 1;

    logic signed [bitWidth-1:0]       in_pixel;
    logic                             in_valid;
    logic                             in_last;
    logic                             in_ready;

    logic signed [bitWidth-1:0]       eng_pixel;
    logic                             eng_valid;
    logic                             eng_sof;
    logic [outputSize*bitWidth-1:0]   eng_scores;

    logic [outputSize*bitWidth-1:0]   out_scores;
    logic [CLS_W-1:0]                 out_class;
    logic signed [bitWidth-1:0]       out_max;
    logic                             out_frame_err;
    logic                             out_valid;
    logic                             out_ready;

    modport slave (
        input  in_pixel, in_valid, in_last, eng_scores, out_ready,
        output in_ready, eng_pixel, eng_valid, eng_sof,
        output out_scores, out_class, out_max, out_frame_err, out_valid
    );

    modport master (
        output in_pixel, in_valid, in_last, eng_scores, out_ready,
        input  in_ready, eng_pixel, eng_valid, eng_sof,
        input  out_scores, out_class, out_max, out_frame_err, out_valid
    );
endinterface

// File: rtl/cnn2d_frame_sequencer.sv
// Frame sequencer for the 2D CNN engine: streams pixels in, waits out the engine latency,
// captures the class scores with their argmax and holds the result for the consumer.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   ACCEPT | taking pixels, counting chan/col/row, forwarding them to engine
//   DRAIN  | input closed, counting pipeLatency cycles before score capture
//   HOLD   | result presented on out_*, waiting for out_valid & out_ready
module cnn2d_frame_sequencer #(
    parameter int bitWidth      = 16,
    parameter int NFRAC         = 10,
    parameter int inputWidth    = 8,
    parameter int inputHeight   = 8,
    parameter int numChan       = 1,
    parameter int outputSize    = 10,
    parameter int pipeLatency   = 4,
    parameter int frameCntWidth = 16
) (
    input  logic                      clk_p,
    input  logic                      reset,
    cnn2d_frame_sequencer_if.slave    bus,
    output logic [frameCntWidth-1:0]  frame_count
);

    localparam int CH_W  = (numChan > 1)     ? $clog2(numChan)     : 1;
    localparam int COL_W = (inputWidth > 1)  ? $clog2(inputWidth)  : 1;
    localparam int ROW_W = (inputHeight > 1) ? $clog2(inputHeight) : 1;
    localparam int CLS_W = (outputSize > 1)  ? $clog2(outputSize)  : 1;
    localparam int DRN_W = $clog2(pipeLatency + 1);

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(numChan - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(inputWidth - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(inputHeight - 1);
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(pipeLatency);

    // Nothing is built here; the block only elaborates for nonsensical parameter sets.
    if (pipeLatency < 1 || NFRAC < 0 || NFRAC >= bitWidth) begin : g_illegal_params
    end

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        DRAIN  = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CH_W-1:0]   chan_cnt;
    logic [COL_W-1:0]  col_cnt;
    logic [ROW_W-1:0]  row_cnt;
    logic [DRN_W-1:0]  drain_cnt;
    logic              frame_err;

    logic signed [bitWidth-1:0]      eng_pixel_q;
    logic                            eng_valid_q;
    logic                            eng_sof_q;
    logic [outputSize*bitWidth-1:0]  out_scores_q;
    logic [CLS_W-1:0]                out_class_q;
    logic signed [bitWidth-1:0]      out_max_q;
    logic                            out_frame_err_q;

    logic nat_end;
    logic first_pix;
    logic accept;
    logic frame_end;
    logic capture;
    logic release_res;
    logic in_ready_c;
    logic out_valid_c;

    logic signed [bitWidth-1:0] best_val;
    logic [CLS_W-1:0]           best_idx;

    assign nat_end   = (chan_cnt == CH_LAST) && (col_cnt == COL_LAST) && (row_cnt == ROW_LAST);
    assign first_pix = (chan_cnt == '0) && (col_cnt == '0) && (row_cnt == '0);

    always_ff @(posedge clk_p) begin
        if (!reset) begin
            state <= ACCEPT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        accept      = 1'b0;
        frame_end   = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state)
            ACCEPT: begin
                // in_ready is gated by reset so the source sees back-pressure while held in reset
                in_ready_c = reset;
                accept     = reset & bus.in_valid;
                frame_end  = accept & (nat_end | bus.in_last);
                if (frame_end) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    release_res = 1'b1;
                    state_nxt   = ACCEPT;
                end
            end
            default: begin
                state_nxt = ACCEPT;
            end
        endcase
    end

    // Strict '>' scanning upward keeps the lowest index on ties.
    always_comb begin
        best_val = bus.eng_scores[bitWidth-1:0];
        best_idx = '0;
        for (int i = 1; i < outputSize; i++) begin
            if ($signed(bus.eng_scores[i*bitWidth +: bitWidth]) > best_val) begin
                best_val = bus.eng_scores[i*bitWidth +: bitWidth];
                best_idx = CLS_W'(i);
            end
        end
    end

    always_ff @(posedge clk_p) begin
        if (!reset) begin
            chan_cnt        <= '0;
            col_cnt         <= '0;
            row_cnt         <= '0;
            drain_cnt       <= '0;
            frame_err       <= 1'b0;
            eng_pixel_q     <= '0;
            eng_valid_q     <= 1'b0;
            eng_sof_q       <= 1'b0;
            out_scores_q    <= '0;
            out_class_q     <= '0;
            out_max_q       <= '0;
            out_frame_err_q <= 1'b0;
            frame_count     <= '0;
        end else begin
            eng_valid_q <= accept;
            eng_sof_q   <= accept & first_pix;

            if (accept) begin
                eng_pixel_q <= bus.in_pixel;
                if (frame_end) begin
                    chan_cnt  <= '0;
                    col_cnt   <= '0;
                    row_cnt   <= '0;
                    frame_err <= nat_end ^ bus.in_last;
                    drain_cnt <= DRN_LOAD;
                end else if (chan_cnt != CH_LAST) begin
                    chan_cnt <= chan_cnt + 1'b1;
                end else begin
                    chan_cnt <= '0;
                    if (col_cnt != COL_LAST) begin
                        col_cnt <= col_cnt + 1'b1;
                    end else begin
                        col_cnt <= '0;
                        row_cnt <= row_cnt + 1'b1;
                    end
                end
            end

            if ((state == DRAIN) && (drain_cnt != '0)) begin
                drain_cnt <= drain_cnt - 1'b1;
            end

            if (capture) begin
                out_scores_q    <= bus.eng_scores;
                out_class_q     <= best_idx;
                out_max_q       <= best_val;
                out_frame_err_q <= frame_err;
            end

            if (release_res) begin
                frame_count <= frame_count + 1'b1;
                frame_err   <= 1'b0;
            end
        end
    end

    assign bus.in_ready      = in_ready_c;
    assign bus.out_valid     = out_valid_c;
    assign bus.eng_pixel     = eng_pixel_q;
    assign bus.eng_valid     = eng_valid_q;
    assign bus.eng_sof       = eng_sof_q;
    assign bus.out_scores    = out_scores_q;
    assign bus.out_class     = out_class_q;
    assign bus.out_max       = out_max_q;
    assign bus.out_frame_err = out_frame_err_q;

endmodule

// File: tb/tb_cnn2d_frame_sequencer.sv
// Self-checking bench for cnn2d_frame_sequencer: default instance (8x8x1, latency 4) and a
// small instance (5x3x2, latency 1, 2-bit frame counter) sharing one clock and reset.
module tb_cnn2d_frame_sequencer;
    localparam int BW     = 16;
    localparam int OS     = 10;
    localparam int NPIX_A = 64;
    localparam int NPIX_B = 30;

    logic clk_p = 1'b0;
    logic reset;
    always #5 clk_p = ~clk_p;

    cnn2d_frame_sequencer_if #(.bitWidth(BW), .outputSize(OS)) bus_a ();
    cnn2d_frame_sequencer_if #(.bitWidth(BW), .outputSize(OS)) bus_b ();
    logic [15:0] fc_a;
    logic [1:0]  fc_b;

    cnn2d_frame_sequencer dut_a (
        .clk_p       (clk_p),
        .reset       (reset),
        .bus         (bus_a),
        .frame_count (fc_a)
    );

    cnn2d_frame_sequencer #(
        .inputWidth    (5),
        .inputHeight   (3),
        .numChan       (2),
        .pipeLatency   (1),
        .frameCntWidth (2)
    ) dut_b (
        .clk_p       (clk_p),
        .reset       (reset),
        .bus         (bus_b),
        .frame_count (fc_b)
    );

    typedef struct {
        logic [BW-1:0] pix;
        logic          sof;
    } pix_exp_t;

    typedef struct {
        logic [3:0]       cls;
        logic [BW-1:0]    mx;
        logic             err;
        logic [OS*BW-1:0] scores;
    } res_exp_t;

    pix_exp_t    pix_q[$];
    res_exp_t    res_q[$];
    int          exp_idx;
    logic [15:0] exp_fc;
    logic [BW-1:0] score_tab [OS];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference argmax scans downward with '>=' so the lowest index ends up winning ties.
    function automatic res_exp_t model_result(input logic err);
        res_exp_t r;
        int best;
        best = OS - 1;
        for (int i = OS - 2; i >= 0; i--) begin
            if ($signed(score_tab[i]) >= $signed(score_tab[best])) best = i;
        end
        r.cls = 4'(best);
        r.mx  = score_tab[best];
        r.err = err;
        r.scores = '0;
        for (int i = 0; i < OS; i++) r.scores[i*BW +: BW] = score_tab[i];
        return r;
    endfunction

    function automatic logic [OS*BW-1:0] pack_scores();
        logic [OS*BW-1:0] v;
        for (int i = 0; i < OS; i++) v[i*BW +: BW] = score_tab[i];
        return v;
    endfunction

    task automatic apply_reset(input int ncyc);
        reset = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_last = 1'b0;
        pix_q.delete(); res_q.delete();
        exp_idx = 0; exp_fc = '0;
        #1;
        n_cmp++;
        if (bus_a.in_ready !== 1'b0 || bus_b.in_ready !== 1'b0)
            begin n_bad++; $display("FAIL reset_in_ready: got a=%b b=%b want 0", bus_a.in_ready, bus_b.in_ready); end
        repeat (ncyc) @(negedge clk_p);
        n_cmp++;
        if (bus_a.eng_valid !== 1'b0 || bus_a.eng_sof !== 1'b0 || bus_a.eng_pixel !== '0 || bus_a.out_valid !== 1'b0)
            begin n_bad++; $display("FAIL reset_eng: got v=%b sof=%b pix=%h ov=%b want all 0", bus_a.eng_valid, bus_a.eng_sof, bus_a.eng_pixel, bus_a.out_valid); end
        n_cmp++;
        if (bus_a.out_scores !== '0 || bus_a.out_class !== '0 || bus_a.out_max !== '0 || bus_a.out_frame_err !== 1'b0 || fc_a !== '0)
            begin n_bad++; $display("FAIL reset_out: got cls=%0d max=%h err=%b fc=%0d want all 0", bus_a.out_class, bus_a.out_max, bus_a.out_frame_err, fc_a); end
        n_cmp++;
        if (bus_b.out_valid !== 1'b0 || bus_b.eng_valid !== 1'b0 || fc_b !== '0)
            begin n_bad++; $display("FAIL reset_b: got ov=%b ev=%b fc=%0d want 0", bus_b.out_valid, bus_b.eng_valid, fc_b); end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus_a.in_ready !== 1'b1)
            begin n_bad++; $display("FAIL reset_release_in_ready: got %b want 1", bus_a.in_ready); end
        @(negedge clk_p);
    endtask

    // Drives one cycle on instance A from a negedge, scoreboards accepted pixels and
    // checks the engine strobe on the following negedge.
    task automatic drive_pixel_a(input logic v, input logic [BW-1:0] pix, input logic last, output logic acc);
        pix_exp_t pe;
        bus_a.in_valid = v; bus_a.in_pixel = pix; bus_a.in_last = last;
        #1;
        acc = v && bus_a.in_ready;
        if (acc) begin
            pe.pix = pix; pe.sof = (exp_idx == 0);
            pix_q.push_back(pe);
            if (exp_idx == NPIX_A - 1 || last) begin
                res_q.push_back(model_result((exp_idx == NPIX_A - 1) != last));
                exp_idx = 0;
            end else begin
                exp_idx++;
            end
        end
        @(negedge clk_p);
        n_cmp++;
        if (bus_a.eng_valid !== acc)
            begin n_bad++; $display("FAIL eng_valid: got %b want %b", bus_a.eng_valid, acc); end
        else if (bus_a.eng_valid === 1'b0 && bus_a.eng_sof !== 1'b0)
            begin n_bad++; $display("FAIL eng_sof_idle: got %b want 0", bus_a.eng_sof); end
        if (acc) begin
            pe = pix_q.pop_front();
            n_cmp++;
            if (bus_a.eng_pixel !== pe.pix || bus_a.eng_sof !== pe.sof)
                begin n_bad++; $display("FAIL eng_pixel: got pix=%h sof=%b want pix=%h sof=%b", bus_a.eng_pixel, bus_a.eng_sof, pe.pix, pe.sof); end
        end
    endtask

    task automatic send_frame_a(input int nsend, input int last_at, input bit rnd);
        int sent;
        int guard;
        logic v;
        logic acc;
        sent = 0; guard = 0;
        while (sent < nsend && guard < 2000) begin
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            drive_pixel_a(v, BW'(sent), (sent == last_at), acc);
            if (acc) sent++;
            guard++;
        end
        bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0;
        n_cmp++;
        if (sent != nsend)
            begin n_bad++; $display("FAIL send_timeout: got %0d accepted want %0d", sent, nsend); end
    endtask

    // Entered on the negedge right after the last accept (cycle t+1).
    task automatic await_result_a(input int exp_lat, output res_exp_t r);
        int c;
        r.cls = '0; r.mx = '0; r.err = 1'b0; r.scores = '0;
        c = 1;
        n_cmp++;
        if (bus_a.in_ready !== 1'b0)
            begin n_bad++; $display("FAIL in_ready_after_last: got %b want 0", bus_a.in_ready); end
        while (bus_a.out_valid !== 1'b1 && c < 100) begin
            @(negedge clk_p);
            c++;
        end
        n_cmp++;
        if (c != exp_lat)
            begin n_bad++; $display("FAIL result_latency: got %0d want %0d", c, exp_lat); end
        n_cmp++;
        if (res_q.size() == 0) begin
            n_bad++; $display("FAIL result_queue: got 0 entries want 1");
        end else begin
            r = res_q.pop_front();
            if (bus_a.out_class !== r.cls || bus_a.out_max !== r.mx || bus_a.out_frame_err !== r.err || bus_a.out_scores !== r.scores)
                begin n_bad++; $display("FAIL result: got cls=%0d max=%h err=%b want cls=%0d max=%h err=%b", bus_a.out_class, bus_a.out_max, bus_a.out_frame_err, r.cls, r.mx, r.err); end
        end
    endtask

    task automatic finish_result_a();
        bus_a.out_ready = 1'b1;
        bus_a.in_valid  = 1'b0;
        @(negedge clk_p);
        exp_fc = exp_fc + 16'd1;
        n_cmp++;
        if (fc_a !== exp_fc || bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1)
            begin n_bad++; $display("FAIL handshake: got fc=%0d ov=%b ir=%b want fc=%0d ov=0 ir=1", fc_a, bus_a.out_valid, bus_a.in_ready, exp_fc); end
    endtask

    task automatic set_scores_a(input logic [BW-1:0] base, input int hi_a, input logic [BW-1:0] va, input int hi_b, input logic [BW-1:0] vb);
        for (int i = 0; i < OS; i++) score_tab[i] = base;
        if (hi_a >= 0) score_tab[hi_a] = va;
        if (hi_b >= 0) score_tab[hi_b] = vb;
        bus_a.eng_scores = pack_scores();
    endtask

    task automatic test_reset();
        apply_reset(3);
    endtask

    task automatic test_nominal();
        res_exp_t r;
        set_scores_a(16'h0000, 7, 16'h0400, -1, 16'h0000);
        bus_a.out_ready = 1'b1;
        send_frame_a(NPIX_A, NPIX_A - 1, 1'b0);
        await_result_a(6, r);
        finish_result_a();
    endtask

    task automatic test_argmax();
        res_exp_t r;
        set_scores_a(16'hFFFB, -1, 16'h0000, -1, 16'h0000);
        send_frame_a(NPIX_A, NPIX_A - 1, 1'b0);
        await_result_a(6, r);
        finish_result_a();
        set_scores_a(16'h8000, 2, 16'h0200, 9, 16'h0200);
        send_frame_a(NPIX_A, NPIX_A - 1, 1'b0);
        await_result_a(6, r);
        finish_result_a();
        set_scores_a(16'hFF00, 9, 16'h7FFF, 0, 16'h8000);
        send_frame_a(NPIX_A, NPIX_A - 1, 1'b0);
        await_result_a(6, r);
        finish_result_a();
    endtask

    task automatic test_backpressure();
        res_exp_t r;
        set_scores_a(16'hFFF0, 4, 16'h0123, 6, 16'h0122);
        bus_a.out_ready = 1'b0;
        send_frame_a(NPIX_A, NPIX_A - 1, 1'b1);
        await_result_a(6, r);
        // Engine scores move and the source keeps pushing while the result is held.
        set_scores_a(16'h0555, 1, 16'h7000, -1, 16'h0000);
        bus_a.in_valid = 1'b1; bus_a.in_pixel = 16'hBEEF;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk_p);
            n_cmp++;
            if (bus_a.out_valid !== 1'b1 || bus_a.in_ready !== 1'b0 || bus_a.eng_valid !== 1'b0 ||
                bus_a.out_class !== r.cls || bus_a.out_max !== r.mx || bus_a.out_scores !== r.scores || fc_a !== exp_fc)
                begin n_bad++; $display("FAIL hold_stable[%0d]: got ov=%b ir=%b cls=%0d max=%h fc=%0d want ov=1 ir=0 cls=%0d max=%h fc=%0d", k, bus_a.out_valid, bus_a.in_ready, bus_a.out_class, bus_a.out_max, fc_a, r.cls, r.mx, exp_fc); end
        end
        finish_result_a();
    endtask

    task automatic test_length_err();
        res_exp_t r;
        set_scores_a(16'h0010, 3, 16'h0020, -1, 16'h0000);
        bus_a.out_ready = 1'b1;
        send_frame_a(41, 40, 1'b0);
        await_result_a(6, r);
        finish_result_a();
        send_frame_a(NPIX_A, -1, 1'b0);
        await_result_a(6, r);
        finish_result_a();
        send_frame_a(NPIX_A, NPIX_A - 1, 1'b0);
        await_result_a(6, r);
        finish_result_a();
    endtask

    task automatic test_reset_mid();
        res_exp_t r;
        set_scores_a(16'h0001, 5, 16'h0300, -1, 16'h0000);
        send_frame_a(30, -1, 1'b0);
        apply_reset(2);
        send_frame_a(NPIX_A, NPIX_A - 1, 1'b0);
        await_result_a(6, r);
        finish_result_a();
        n_cmp++;
        if (fc_a !== 16'd1)
            begin n_bad++; $display("FAIL reset_mid_count: got %0d want 1", fc_a); end
    endtask

    task automatic test_param_sweep();
        res_exp_t r;
        logic acc;
        logic [BW-1:0] pix;
        logic [1:0] fcb_exp;
        int sent;
        int guard;
        int c;
        fcb_exp = 2'd0;
        for (int i = 0; i < OS; i++) score_tab[i] = 16'hFF00;
        score_tab[5] = 16'h0123;
        score_tab[0] = 16'h0100;
        bus_b.eng_scores = pack_scores();
        bus_b.out_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            sent = 0; guard = 0;
            while (sent < NPIX_B && guard < 200) begin
                pix = BW'(sent + 100 * f);
                bus_b.in_valid = 1'b1; bus_b.in_pixel = pix; bus_b.in_last = (sent == NPIX_B - 1);
                #1;
                acc = bus_b.in_ready;
                if (acc && sent == NPIX_B - 1) res_q.push_back(model_result(1'b0));
                @(negedge clk_p);
                n_cmp++;
                if (bus_b.eng_valid !== acc || (acc && (bus_b.eng_pixel !== pix || bus_b.eng_sof !== (sent == 0))))
                    begin n_bad++; $display("FAIL sweep_eng[%0d.%0d]: got v=%b pix=%h sof=%b want v=%b pix=%h sof=%b", f, sent, bus_b.eng_valid, bus_b.eng_pixel, bus_b.eng_sof, acc, pix, (sent == 0)); end
                if (acc) sent++;
                guard++;
            end
            bus_b.in_valid = 1'b0; bus_b.in_last = 1'b0;
            c = 1;
            while (bus_b.out_valid !== 1'b1 && c < 50) begin
                @(negedge clk_p);
                c++;
            end
            n_cmp++;
            if (c != 3)
                begin n_bad++; $display("FAIL sweep_latency[%0d]: got %0d want 3", f, c); end
            n_cmp++;
            if (res_q.size() == 0) begin
                n_bad++; $display("FAIL sweep_queue[%0d]: got 0 entries want 1", f);
            end else begin
                r = res_q.pop_front();
                if (bus_b.out_class !== r.cls || bus_b.out_max !== r.mx || bus_b.out_frame_err !== r.err)
                    begin n_bad++; $display("FAIL sweep_result[%0d]: got cls=%0d max=%h err=%b want cls=%0d max=%h err=%b", f, bus_b.out_class, bus_b.out_max, bus_b.out_frame_err, r.cls, r.mx, r.err); end
            end
            @(negedge clk_p);
            fcb_exp = fcb_exp + 2'd1;
            n_cmp++;
            if (fc_b !== fcb_exp || bus_b.in_ready !== 1'b1)
                begin n_bad++; $display("FAIL sweep_count[%0d]: got fc=%0d ir=%b want fc=%0d ir=1", f, fc_b, bus_b.in_ready, fcb_exp); end
        end
    endtask

    initial begin
        reset = 1'b0;
        bus_a.in_pixel = '0; bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0;
        bus_a.eng_scores = '0; bus_a.out_ready = 1'b1;
        bus_b.in_pixel = '0; bus_b.in_valid = 1'b0; bus_b.in_last = 1'b0;
        bus_b.eng_scores = '0; bus_b.out_ready = 1'b1;
        for (int i = 0; i < OS; i++) score_tab[i] = '0;
        exp_idx = 0; exp_fc = '0;
        @(negedge clk_p);
        test_reset();
        test_nominal();
        test_argmax();
        test_backpressure();
        test_length_err();
        test_reset_mid();
        test_param_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
